// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter in front of the register file's single write port.
// ALU results issue with one cycle of latency. Memory results are buffered in a
// circular FIFO and issue in arrival order whenever no ALU result competes.
// Optional macro WB_BYPASS_EN: a memory result that arrives while the FIFO is
// empty and no ALU result is present skips the FIFO and issues with latency 1.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_dest,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  input  logic [4:0]             mem_dest,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic [4:0]             src_addr1,
  input  logic [4:0]             src_addr2,
  output logic                   hazard,
  output logic                   regWrite,
  output logic [DATA_W-1:0]      write_back,
  output logic [4:0]             dest,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0]  live;
  logic [4:0]        q_dest [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic alu_acc;
  logic mem_acc;
  logic bypass;
  logic push;
  logic pop;
  logic push_killed;

  // Readiness comes only from the registered count; a same-cycle pop does not free a slot.
  assign mem_ready   = (fifo_count < DEPTH_C);
  assign alu_acc     = alu_valid && (alu_dest != 5'd0);
  assign mem_acc     = mem_valid && mem_ready && (mem_dest != 5'd0);
`ifdef WB_BYPASS_EN
  assign bypass      = mem_acc && (fifo_count == '0) && !alu_acc;
`else
  assign bypass      = 1'b0;
`endif
  assign push        = mem_acc && !bypass;
  assign pop         = !alu_acc && (fifo_count != '0);
  // A memory result arriving alongside an ALU result for the same register is the older write.
  assign push_killed = alu_acc && (alu_dest == mem_dest);

  // FIFO storage and live bits: ALU kills, pop retires the head, push fills the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_dest[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alu_acc && (q_dest[i] == alu_dest)) live[i] <= 1'b0;
      end
      if (pop) live[rd_ptr] <= 1'b0;
      if (push) begin
        live[wr_ptr]   <= !push_killed;
        q_dest[wr_ptr] <= mem_dest;
        q_data[wr_ptr] <= mem_data;
      end
    end
  end

  // Circular pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered write port: ALU first, then FIFO head, then bypassed memory result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite   <= 1'b0;
      write_back <= '0;
      dest       <= '0;
    end else if (alu_acc) begin
      regWrite   <= 1'b1;
      write_back <= alu_data;
      dest       <= alu_dest;
    end else if (pop) begin
      regWrite   <= live[rd_ptr];
      write_back <= q_data[rd_ptr];
      dest       <= q_dest[rd_ptr];
    end else if (bypass) begin
      regWrite   <= 1'b1;
      write_back <= mem_data;
      dest       <= mem_dest;
    end else begin
      regWrite   <= 1'b0;
    end
  end

  // Hazard: any live queued entry targeting a nonzero source register.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live[i] && (((src_addr1 != 5'd0) && (q_dest[i] == src_addr1)) ||
                      ((src_addr2 != 5'd0) && (q_dest[i] == src_addr2))))
        hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (default DEPTH=4, DATA_W=32).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  src_addr1;
  logic [4:0]  src_addr2;
  logic        hazard;
  logic        regWrite;
  logic [31:0] write_back;
  logic [4:0]  dest;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;

  wb_arbiter #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .src_addr1(src_addr1), .src_addr2(src_addr2), .hazard(hazard),
    .regWrite(regWrite), .write_back(write_back), .dest(dest),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    src_addr1 = '0;   src_addr2 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    tests++; if (regWrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %0b want 0", regWrite); end
    tests++; if (write_back !== 32'h0) begin fails++; $display("FAIL reset_wb got %h want 0", write_back); end
    tests++; if (dest !== 5'd0) begin fails++; $display("FAIL reset_dest got %0d want 0", dest); end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", mem_ready); end
    reset = 1'b0;
    step();
    tests++; if (mem_ready !== 1'b1 || regWrite !== 1'b0) begin fails++; $display("FAIL post_reset ready=%0b rw=%0b want 1,0", mem_ready, regWrite); end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_dest = 5'b01000; alu_data = 32'h5;
    step();
    alu_valid = 1'b0;
    tests++; if (regWrite !== 1'b1 || dest !== 5'b01000 || write_back !== 32'h5) begin
      fails++; $display("FAIL alu_issue rw=%0b dest=%0d wb=%h want 1,8,5", regWrite, dest, write_back); end
    step();
    tests++; if (regWrite !== 1'b0 || dest !== 5'b01000 || write_back !== 32'h5) begin
      fails++; $display("FAIL alu_hold rw=%0b dest=%0d wb=%h want 0,8,5", regWrite, dest, write_back); end
  endtask

  task automatic test_mem_delay();
    alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'h20;
    mem_valid = 1'b1; mem_dest = 5'b10001; mem_data = 32'hA;
    step();
    mem_valid = 1'b0;
    tests++; if (fifo_count !== 3'd1 || regWrite !== 1'b1 || dest !== 5'd2) begin
      fails++; $display("FAIL delay_e1 cnt=%0d rw=%0b dest=%0d want 1,1,2", fifo_count, regWrite, dest); end
    alu_dest = 5'd3; alu_data = 32'h30;
    step();
    tests++; if (fifo_count !== 3'd1 || dest !== 5'd3) begin
      fails++; $display("FAIL delay_e2 cnt=%0d dest=%0d want 1,3", fifo_count, dest); end
    alu_dest = 5'd4; alu_data = 32'h40;
    step();
    tests++; if (fifo_count !== 3'd1 || dest !== 5'd4 || write_back !== 32'h40) begin
      fails++; $display("FAIL delay_e3 cnt=%0d dest=%0d wb=%h want 1,4,40", fifo_count, dest, write_back); end
    alu_valid = 1'b0;
    step();
    tests++; if (fifo_count !== 3'd0 || regWrite !== 1'b1 || dest !== 5'b10001 || write_back !== 32'hA) begin
      fails++; $display("FAIL delay_mem cnt=%0d rw=%0b dest=%0d wb=%h want 0,1,17,a", fifo_count, regWrite, dest, write_back); end
    step();
    tests++; if (regWrite !== 1'b0) begin fails++; $display("FAIL delay_idle rw=%0b want 0", regWrite); end
  endtask

  task automatic test_full();
    alu_valid = 1'b1; alu_dest = 5'd30; alu_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_dest = 5'(20 + k); mem_data = 32'h100 + 32'(k);
      step();
      tests++; if (fifo_count !== 3'(k + 1)) begin
        fails++; $display("FAIL full_count%0d got %0d want %0d", k, fifo_count, k + 1); end
    end
    tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %0b want 0", mem_ready); end
    mem_dest = 5'd24; mem_data = 32'h1FF;
    step();
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_drop cnt=%0d want 4", fifo_count); end
    mem_valid = 1'b0; alu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      tests++; if (regWrite !== 1'b1 || dest !== 5'(20 + k) || write_back !== 32'h100 + 32'(k) || fifo_count !== 3'(3 - k)) begin
        fails++; $display("FAIL full_pop%0d rw=%0b dest=%0d wb=%h cnt=%0d want 1,%0d,%h,%0d",
                          k, regWrite, dest, write_back, fifo_count, 20 + k, 32'h100 + 32'(k), 3 - k); end
    end
    step();
    tests++; if (regWrite !== 1'b0) begin fails++; $display("FAIL full_extra rw=%0b want 0", regWrite); end
  endtask

  task automatic test_kill();
    alu_valid = 1'b1; alu_dest = 5'd10; alu_data = 32'h1;
    mem_valid = 1'b1; mem_dest = 5'b01001; mem_data = 32'h99;
    step();
    mem_valid = 1'b0; src_addr1 = 5'b01001;
    #1;
    tests++; if (hazard !== 1'b1) begin fails++; $display("FAIL kill_hz_before got %0b want 1", hazard); end
    alu_dest = 5'b01001; alu_data = 32'h7;
    step();
    tests++; if (regWrite !== 1'b1 || dest !== 5'b01001 || write_back !== 32'h7 || hazard !== 1'b0 || fifo_count !== 3'd1) begin
      fails++; $display("FAIL kill_alu rw=%0b dest=%0d wb=%h hz=%0b cnt=%0d want 1,9,7,0,1", regWrite, dest, write_back, hazard, fifo_count); end
    alu_valid = 1'b0;
    step();
    tests++; if (regWrite !== 1'b0 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL kill_pop rw=%0b cnt=%0d want 0,0", regWrite, fifo_count); end
    alu_valid = 1'b1; alu_dest = 5'd12; alu_data = 32'h3;
    mem_valid = 1'b1; mem_dest = 5'd12; mem_data = 32'h44;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0; src_addr1 = 5'd12;
    #1;
    tests++; if (fifo_count !== 3'd1 || hazard !== 1'b0 || write_back !== 32'h3) begin
      fails++; $display("FAIL samecyc_kill cnt=%0d hz=%0b wb=%h want 1,0,3", fifo_count, hazard, write_back); end
    step();
    tests++; if (regWrite !== 1'b0 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL samecyc_pop rw=%0b cnt=%0d want 0,0", regWrite, fifo_count); end
    src_addr1 = '0;
  endtask

  task automatic test_hazard();
    alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 32'h0;
    mem_valid = 1'b1; mem_dest = 5'b10010; mem_data = 32'h18;
    step();
    mem_valid = 1'b0;
    src_addr1 = 5'b10010; src_addr2 = 5'd0; #1;
    tests++; if (hazard !== 1'b1) begin fails++; $display("FAIL hz_src1 got %0b want 1", hazard); end
    src_addr1 = 5'd0; src_addr2 = 5'b10010; #1;
    tests++; if (hazard !== 1'b1) begin fails++; $display("FAIL hz_src2 got %0b want 1", hazard); end
    src_addr2 = 5'd0; #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL hz_zero got %0b want 0", hazard); end
    src_addr1 = 5'd5; #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL hz_other got %0b want 0", hazard); end
    alu_valid = 1'b0;
    step();
    src_addr1 = 5'b10010; #1;
    tests++; if (regWrite !== 1'b1 || dest !== 5'b10010 || hazard !== 1'b0) begin
      fails++; $display("FAIL hz_drain rw=%0b dest=%0d hz=%0b want 1,18,0", regWrite, dest, hazard); end
    src_addr1 = 5'd0;
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'hDEAD;
    mem_valid = 1'b1; mem_dest = 5'd0; mem_data = 32'hBEEF;
    step();
    idle();
    tests++; if (regWrite !== 1'b0 || fifo_count !== 3'd0 || dest !== 5'b10010 || hazard !== 1'b0) begin
      fails++; $display("FAIL dest0 rw=%0b cnt=%0d dest=%0d hz=%0b want 0,0,18,0", regWrite, fifo_count, dest, hazard); end
  endtask

  task automatic test_bypass();
    idle();
    mem_valid = 1'b1; mem_dest = 5'd21; mem_data = 32'h55;
    step();
    mem_valid = 1'b0;
`ifdef WB_BYPASS_EN
    tests++; if (regWrite !== 1'b1 || dest !== 5'd21 || write_back !== 32'h55 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL bypass rw=%0b dest=%0d wb=%h cnt=%0d want 1,21,55,0", regWrite, dest, write_back, fifo_count); end
`else
    tests++; if (regWrite !== 1'b0 || fifo_count !== 3'd1) begin
      fails++; $display("FAIL nobypass_e1 rw=%0b cnt=%0d want 0,1", regWrite, fifo_count); end
    step();
    tests++; if (regWrite !== 1'b1 || dest !== 5'd21 || write_back !== 32'h55 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL nobypass_e2 rw=%0b dest=%0d wb=%h cnt=%0d want 1,21,55,0", regWrite, dest, write_back, fifo_count); end
`endif
    step();
    tests++; if (regWrite !== 1'b0) begin fails++; $display("FAIL bypass_idle rw=%0b want 0", regWrite); end
  endtask

  task automatic test_back_to_back();
    alu_valid = 1'b1; alu_dest = 5'd6; alu_data = 32'h61;
    step();
    tests++; if (regWrite !== 1'b1 || dest !== 5'd6 || write_back !== 32'h61) begin
      fails++; $display("FAIL b2b_0 rw=%0b dest=%0d wb=%h want 1,6,61", regWrite, dest, write_back); end
    alu_dest = 5'd7; alu_data = 32'h71;
    mem_valid = 1'b1; mem_dest = 5'd11; mem_data = 32'hB1;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tests++; if (regWrite !== 1'b1 || dest !== 5'd7 || write_back !== 32'h71) begin
      fails++; $display("FAIL b2b_1 rw=%0b dest=%0d wb=%h want 1,7,71", regWrite, dest, write_back); end
    step();
    tests++; if (regWrite !== 1'b1 || dest !== 5'd11 || write_back !== 32'hB1) begin
      fails++; $display("FAIL b2b_2 rw=%0b dest=%0d wb=%h want 1,11,b1", regWrite, dest, write_back); end
    step();
  endtask

  task automatic test_async_reset();
    alu_valid = 1'b1; alu_dest = 5'd13; alu_data = 32'hD;
    mem_valid = 1'b1; mem_dest = 5'd14; mem_data = 32'hE;
    step();
    idle();
    tests++; if (regWrite !== 1'b1 || fifo_count !== 3'd1) begin
      fails++; $display("FAIL ar_pre rw=%0b cnt=%0d want 1,1", regWrite, fifo_count); end
    #1 reset = 1'b1;
    #1;
    src_addr1 = 5'd14; #1;
    tests++; if (regWrite !== 1'b0 || fifo_count !== 3'd0 || dest !== 5'd0 || mem_ready !== 1'b1 || hazard !== 1'b0) begin
      fails++; $display("FAIL ar_async rw=%0b cnt=%0d dest=%0d rdy=%0b hz=%0b want 0,0,0,1,0",
                        regWrite, fifo_count, dest, mem_ready, hazard); end
    reset = 1'b0;
    src_addr1 = '0;
    step();
    tests++; if (regWrite !== 1'b0 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL ar_after rw=%0b cnt=%0d want 0,0", regWrite, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_delay();
    test_full();
    test_kill();
    test_hazard();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
